// File: rtl/bcd_display_pkg.sv
// Shared constants and state encoding for the BCD decimal display path.
package bcd_display_pkg;

   localparam int BCD_W   = 4;
   localparam int DEC_W   = 10;
   localparam int BCD_MAX = 9;

   // The controller only leaves IDLE on its first frame and returns only through reset.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

endpackage : bcd_display_pkg

// File: rtl/bcd_to_onehot10.sv
// BCD 8421 digit to 1-of-10 decimal line decoder; codes 10..15 produce no line.
module bcd_to_onehot10
   import bcd_display_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [DEC_W-1:0] dec,
   output logic             valid
);

   // Decode a legal digit to its line; an illegal code leaves all lines dark.
   always_comb begin
      dec   = {DEC_W{1'b0}};
      valid = 1'b0;
      if (bcd <= BCD_W'(BCD_MAX)) begin
         dec   = DEC_W'(10'b00_0000_0001) << bcd;
         valid = 1'b1;
      end else begin
         dec   = {DEC_W{1'b0}};
         valid = 1'b0;
      end
   end

endmodule : bcd_to_onehot10

// File: rtl/bcd_decimal_scan_controller.sv
// Time-multiplexed scan controller: double-buffered BCD frame, prescaled digit
// index, one-hot decimal decode and registered column/line drive.
module bcd_decimal_scan_controller
   import bcd_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
   input  logic                        blank_en,
   output logic [NUM_DIGITS-1:0]       digit_sel,
   output logic [DEC_W-1:0]            dec_out,
   output logic                        digit_err,
   output logic                        frame_done
);

   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   scan_state_e                  state_r;
   logic [BCD_W*NUM_DIGITS-1:0]  active_r;
   logic [BCD_W*NUM_DIGITS-1:0]  pending_r;
   logic                         pending_valid_r;
   logic [PRESC_W-1:0]           presc_r;
   logic [IDX_W-1:0]             index_r;

   logic [NUM_DIGITS-1:0]        digit_sel_r;
   logic [DEC_W-1:0]             dec_out_r;
   logic                         digit_err_r;
   logic                         frame_done_r;

   logic                         xfer_s;
   logic                         term_s;
   logic                         last_s;
   logic                         wrap_s;
   logic [BCD_W-1:0]             digit_s;
   logic [NUM_DIGITS-1:0]        sel_s;
   logic [DEC_W-1:0]             dec_s;
   logic                         valid_s;

   assign load_ready = ~pending_valid_r;
   assign xfer_s     = load_valid & ~pending_valid_r;
   assign term_s     = (presc_r == PRESC_W'(SCAN_DIV - 1));
   assign last_s     = (index_r == IDX_W'(NUM_DIGITS - 1));
   assign wrap_s     = (state_r == SCAN) & term_s & last_s;

   assign digit_sel  = digit_sel_r;
   assign dec_out    = dec_out_r;
   assign digit_err  = digit_err_r;
   assign frame_done = frame_done_r;

   // Select the active digit and column for the current index.
   always_comb begin
      digit_s = {BCD_W{1'b0}};
      sel_s   = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (index_r == IDX_W'(k)) begin
            digit_s  = active_r[k*BCD_W +: BCD_W];
            sel_s[k] = 1'b1;
         end else begin
            sel_s[k] = 1'b0;
         end
      end
   end

   bcd_to_onehot10 u_decode (
      .bcd   (digit_s),
      .dec   (dec_s),
      .valid (valid_s)
   );

   // Frame buffering, prescaler and scan index; new data only lands on a frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         active_r        <= '0;
         pending_r       <= '0;
         pending_valid_r <= 1'b0;
         presc_r         <= '0;
         index_r         <= '0;
         frame_done_r    <= 1'b0;
      end else begin
         frame_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               presc_r <= '0;
               if (xfer_s) begin
                  active_r <= load_data;
                  index_r  <= '0;
                  state_r  <= SCAN;
               end
            end
            SCAN: begin
               if (term_s) begin
                  presc_r <= '0;
                  index_r <= last_s ? '0 : index_r + IDX_W'(1);
               end else begin
                  presc_r <= presc_r + PRESC_W'(1);
               end
               if (wrap_s) begin
                  frame_done_r <= 1'b1;
                  if (pending_valid_r) begin
                     active_r        <= pending_r;
                     pending_valid_r <= 1'b0;
                  end else if (xfer_s) begin
                     active_r <= load_data;
                  end
               end else if (xfer_s) begin
                  pending_r       <= load_data;
                  pending_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Registered column/line drive, one cycle behind index and active frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_sel_r <= '0;
         dec_out_r   <= '0;
         digit_err_r <= 1'b0;
      end else if (state_r == SCAN) begin
         digit_sel_r <= blank_en ? {NUM_DIGITS{1'b0}} : sel_s;
         dec_out_r   <= blank_en ? {DEC_W{1'b0}} : dec_s;
         digit_err_r <= ~valid_s;
      end else begin
         digit_sel_r <= '0;
         dec_out_r   <= '0;
         digit_err_r <= 1'b0;
      end
   end

endmodule : bcd_decimal_scan_controller
